uart_tx_arbiter: RTL and testbench

//  Shares the single uart_tx transmitter between N_REQ byte sources (RX echo path, status reporter, LCD mirror, ...).

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx between N_REQ byte sources. Round-robin, one byte per
//   grant; sequences the tx_start/tx_busy handshake, keeps an idle guard gap
//   between frames and holds off new grants while a baud change settles.
// Ports
//   i_clk, i_rst     clock, async active-high reset
//   i_req/i_req_data per-source request and byte (source i at [i*DATA_W +: DATA_W])
//   o_ack            one-cycle pulse, byte of source i accepted
//   o_tx_data        byte to uart_tx, held from START until the next grant
//   o_tx_start       one-cycle start strobe to uart_tx
//   i_tx_busy        uart_tx frame in progress (already synchronised)
//   i_cfg_pulse      baud/config change strobe, blocks grants for GUARD_CYC
//   o_grant_id       index of last granted source
//   o_active         FSM not idle
//   o_tmo_err        sticky: tx_busy never rose within BUSY_TMO cycles
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int GUARD_CYC = 16,
  parameter int BUSY_TMO  = 4096,
  localparam int GID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_ack,
  output logic [DATA_W-1:0]       o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_busy,
  input  logic                    i_cfg_pulse,
  output logic [GID_W-1:0]        o_grant_id,
  output logic                    o_active,
  output logic                    o_tmo_err
);

  localparam int CNT_MAX  = (BUSY_TMO > GUARD_CYC) ? BUSY_TMO : GUARD_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int HOLD_W   = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;
  // The cycle in which WAIT_DONE sees tx_busy low is the first guard cycle,
  // so GUARD itself runs GUARD_CYC-1 more cycles. With the IDLE grant cycle
  // and the START cycle this gives GUARD_CYC+2 from busy fall to tx_start.
  localparam int GUARD_LD = (GUARD_CYC > 0) ? GUARD_CYC - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_GUARD
  } state_t;

  state_t              r_state;
  logic [N_REQ-1:0]    r_ack;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_tx_start;
  logic [GID_W-1:0]    r_grant_id;
  logic                r_tmo_err;
  logic [CNT_W-1:0]    r_cnt;
  logic [HOLD_W-1:0]   r_hold;

  logic [DATA_W-1:0]   w_bytes [N_REQ];
  logic                w_found;
  logic [GID_W-1:0]    w_pick;
  int                  w_idx;
  logic                w_grant;

  for (genvar g = 0; g < N_REQ; g++) begin : g_byte
    assign w_bytes[g] = i_req_data[g*DATA_W +: DATA_W];
  end

  // Scan from the source after the last grant, wrapping; a source with req
  // held is therefore only re-served after every other pending source.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = int'(r_grant_id) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && i_req[GID_W'(w_idx)]) begin
        w_found = 1'b1;
        w_pick  = GID_W'(w_idx);
      end
    end
  end

  // A cfg strobe in the grant cycle wins over the grant.
  assign w_grant = w_found && (r_hold == '0) && !i_cfg_pulse;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_ack      <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_grant_id <= GID_W'(N_REQ - 1);
      r_tmo_err  <= 1'b0;
      r_cnt      <= '0;
      r_hold     <= '0;
    end else begin
      r_ack      <= '0;
      r_tx_start <= 1'b0;

      if (i_cfg_pulse)        r_hold <= HOLD_W'(GUARD_CYC);
      else if (r_hold != '0)  r_hold <= r_hold - 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_tx_data     <= w_bytes[w_pick];
            r_grant_id    <= w_pick;
            r_ack[w_pick] <= 1'b1;
            r_state       <= S_START;
          end
        end
        S_START: begin
          r_tx_start <= 1'b1;
          r_cnt      <= '0;
          r_state    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (i_tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == CNT_W'(BUSY_TMO)) begin
            // Byte is dropped; still observe the guard before the next grant.
            r_tmo_err <= 1'b1;
            r_cnt     <= CNT_W'(GUARD_LD);
            r_state   <= S_GUARD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!i_tx_busy) begin
            r_cnt   <= CNT_W'(GUARD_LD);
            r_state <= S_GUARD;
          end
        end
        S_GUARD: begin
          if (r_cnt <= CNT_W'(1)) r_state <= S_IDLE;
          else                    r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ack      = r_ack;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_grant_id = r_grant_id;
  assign o_tmo_err  = r_tmo_err;
  assign o_active   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-source byte queues drive req, a uart_tx
// busy model answers tx_start, and a scoreboard of (source, byte) entries
// pushed with the stimulus is checked at every ack and tx_start.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int GC = 16;
  localparam int TMO = 4096;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic [DW-1:0]   tx_data;
  logic            tx_start;
  logic            tx_busy;
  logic            cfg_pulse;
  logic [GW-1:0]   grant_id;
  logic            active;
  logic            tmo_err;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .GUARD_CYC(GC), .BUSY_TMO(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_data(req_data),
    .o_ack(ack), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_tx_busy(tx_busy), .i_cfg_pulse(cfg_pulse), .o_grant_id(grant_id),
    .o_active(active), .o_tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [GW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] src_q [N][$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int ack_cnt = 0, start_cnt = 0;
  int last_ack_cyc = 0, last_start_cyc = 0, busy_fall_cyc = 0;
  int busy_len = 20;
  bit busy_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Sources: present queue head, drop it once acked.
  initial begin
    req = '0;
    req_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        req[i] = (src_q[i].size() > 0);
        if (src_q[i].size() > 0) req_data[i*DW +: DW] = src_q[i][0];
        else                     req_data[i*DW +: DW] = '0;
      end
    end
  end

  // uart_tx model: busy rises 3 cycles after tx_start, lasts busy_len cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && busy_en && !rst) begin
        repeat (3) @(negedge clk);
        tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        tx_busy = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
  end

  // Scoreboard: ack must name the expected source; tx_start must follow ack
  // by one cycle and carry the expected byte and grant id.
  initial begin : mon
    exp_t       e;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ack != '0) begin
          ack_cnt++;
          last_ack_cyc = cyc;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL ack_unexpected: ack=%b with nothing expected", ack);
          end else begin
            oh = '0;
            oh[exp_q[0].id] = 1'b1;
            if (ack !== oh) begin
              n_fail++;
              $display("FAIL ack_order: ack=%b expected %b", ack, oh);
            end
          end
        end
        if (tx_start) begin
          start_cnt++;
          last_start_cyc = cyc;
          n_tests++;
          if (cyc != last_ack_cyc + 1) begin
            n_fail++;
            $display("FAIL start_latency: tx_start %0d cycles after ack, expected 1", cyc - last_ack_cyc);
          end
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL start_unexpected: tx_start with nothing expected");
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e.data || grant_id !== e.id) begin
              n_fail++;
              $display("FAIL start_data: got src %0d byte %h, expected src %0d byte %h",
                       grant_id, tx_data, e.id, e.data);
            end
          end
        end
      end
    end
  end

  task automatic push(input int i, input logic [DW-1:0] d);
    src_q[i].push_back(d);
    exp_q.push_back('{GW'(i), d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_pulse = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    ack_cnt = 0;
    start_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_start(input int budget, output bit ok);
    int s0 = start_cnt;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (start_cnt != s0) ok = 1'b1;
    end
  endtask

  task automatic wait_fall(input int budget, output bit ok);
    int f0 = busy_fall_cyc;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (busy_fall_cyc != f0) ok = 1'b1;
    end
  endtask

  task automatic wait_busy(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (tx_busy) ok = 1'b1;
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && req == '0 && !active && !tx_busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_pulse = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (ack !== '0)       begin n_fail++; $display("FAIL rst_ack: got %b expected 0", ack); end
    n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b expected 0", tx_start); end
    n_tests++; if (tx_data !== '0)   begin n_fail++; $display("FAIL rst_data: got %h expected 00", tx_data); end
    n_tests++; if (grant_id !== GW'(N-1)) begin n_fail++; $display("FAIL rst_gid: got %0d expected %0d", grant_id, N-1); end
    n_tests++; if (active !== 1'b0)  begin n_fail++; $display("FAIL rst_active: got %b expected 0", active); end
    n_tests++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL rst_tmo: got %b expected 0", tmo_err); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (active !== 1'b0 || tx_start !== 1'b0) begin n_fail++; $display("FAIL idle_quiet: active=%b start=%b expected 0/0", active, tx_start); end
  endtask

  task automatic test_single();
    bit ok;
    int p;
    do_reset();
    busy_len = 100;
    push(0, 8'h41);
    wait_start(50, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_start: no tx_start within 50 cycles"); end
    wait_fall(200, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_fall: busy never fell"); end
    p = busy_fall_cyc;
    wait_cyc(p + GC - 1);
    n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL single_guard: active=%b at fall+%0d, expected 1", active, GC-1); end
    wait_cyc(p + GC + 2);
    n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL single_idle: active=%b at fall+%0d, expected 0", active, GC+2); end
    wait_drain(100, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_drain: not idle after frame"); end
    n_tests++; if (ack_cnt != 1 || start_cnt != 1) begin n_fail++; $display("FAIL single_counts: acks %0d starts %0d, expected 1/1", ack_cnt, start_cnt); end
    n_tests++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_hold: tx_data %h expected 41", tx_data); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    busy_len = 20;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, DW'(8'h10 + i));
    for (int k = 0; k < 2*N; k++) begin
      wait_start(200, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rr_start: start %0d missing", k); end
      if (k > 0) begin
        n_tests++;
        if (last_start_cyc - busy_fall_cyc != GC + 2) begin
          n_fail++;
          $display("FAIL rr_gap: busy-fall to tx_start %0d cycles, expected %0d", last_start_cyc - busy_fall_cyc, GC+2);
        end
      end
    end
    wait_drain(200, ok);
    n_tests++; if (!ok || start_cnt != 2*N) begin n_fail++; $display("FAIL rr_drain: ok=%0d starts %0d expected %0d", ok, start_cnt, 2*N); end
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset();
    busy_len = 10;
    src_q[2].push_back(8'h20);
    exp_q.push_back('{2'd2, 8'h20});
    wait_busy(100, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL fair_busy: first frame never started"); end
    // Source 2 keeps requesting; source 1 joins while the frame is on the wire.
    for (int j = 1; j < 4; j++) src_q[2].push_back(DW'(8'h20 + j));
    src_q[1].push_back(8'h31);
    src_q[1].push_back(8'h32);
    exp_q.push_back('{2'd1, 8'h31});
    exp_q.push_back('{2'd2, 8'h21});
    exp_q.push_back('{2'd1, 8'h32});
    exp_q.push_back('{2'd2, 8'h22});
    exp_q.push_back('{2'd2, 8'h23});
    wait_drain(600, ok);
    n_tests++; if (!ok || ack_cnt != 6) begin n_fail++; $display("FAIL fair_drain: ok=%0d acks %0d expected 6", ok, ack_cnt); end
  endtask

  task automatic test_cfg_hold();
    bit ok;
    int p, q, x;
    do_reset();
    busy_len = 20;
    push(0, 8'h50);
    push(0, 8'h51);
    wait_busy(100, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL cfg_busy: first frame never started"); end
    repeat (2) @(negedge clk);
    cfg_pulse = 1'b1;
    @(negedge clk);
    cfg_pulse = 1'b0;
    n_tests++; if (active !== 1'b1 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL cfg_abort: active=%b busy=%b expected 1/1", active, tx_busy); end
    wait_fall(100, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL cfg_fall: frame did not complete"); end
    p = busy_fall_cyc;
    wait_cyc(p + 5);
    cfg_pulse = 1'b1;
    q = cyc;
    @(negedge clk);
    cfg_pulse = 1'b0;
    wait_start(100, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL cfg_start: second byte never started"); end
    x = last_start_cyc;
    n_tests++; if (x - q < GC) begin n_fail++; $display("FAIL cfg_hold: tx_start %0d cycles after cfg, expected >= %0d", x - q, GC); end
    n_tests++; if (x - p <= GC + 2) begin n_fail++; $display("FAIL cfg_delay: gap %0d cycles, expected > %0d", x - p, GC+2); end
    wait_drain(200, ok);
    n_tests++; if (!ok || ack_cnt != 2) begin n_fail++; $display("FAIL cfg_drain: ok=%0d acks %0d expected 2", ok, ack_cnt); end
  endtask

  task automatic test_timeout();
    bit ok;
    int s;
    do_reset();
    busy_en = 1'b0;
    push(3, 8'h77);
    wait_start(50, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_start: no tx_start"); end
    s = last_start_cyc;
    wait_cyc(s + TMO);
    n_tests++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: tmo_err=%b at start+%0d, expected 0", tmo_err, TMO); end
    wait_cyc(s + TMO + 1);
    n_tests++; if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL tmo_set: tmo_err=%b at start+%0d, expected 1", tmo_err, TMO+1); end
    wait_cyc(s + TMO + 1 + GC);
    n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: active=%b after guard, expected 0", active); end
    busy_en = 1'b1;
    push(0, 8'h78);
    wait_drain(200, ok);
    n_tests++; if (!ok || start_cnt != 2) begin n_fail++; $display("FAIL tmo_next: ok=%0d starts %0d expected 2", ok, start_cnt); end
    n_tests++; if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: tmo_err=%b expected 1", tmo_err); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    do_reset();
    n_tests++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL rmf_tmo_clr: tmo_err=%b expected 0", tmo_err); end
    busy_len = 40;
    push(2, 8'h62);
    wait_busy(100, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rmf_busy: frame never started"); end
    src_q[3].push_back(8'h63);
    src_q[1].push_back(8'h61);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (ack !== '0 || tx_start !== 1'b0 || active !== 1'b0) begin n_fail++; $display("FAIL rmf_outs: ack=%b start=%b active=%b expected 0/0/0", ack, tx_start, active); end
    n_tests++; if (grant_id !== GW'(N-1) || tx_data !== '0) begin n_fail++; $display("FAIL rmf_gid: gid=%0d data=%h expected %0d/00", grant_id, tx_data, N-1); end
    exp_q.push_back('{2'd1, 8'h61});
    exp_q.push_back('{2'd3, 8'h63});
    ack_cnt = 0;
    start_cnt = 0;
    for (int k = 0; k < 100 && tx_busy; k++) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_drain(300, ok);
    n_tests++; if (!ok || ack_cnt != 2) begin n_fail++; $display("FAIL rmf_drain: ok=%0d acks %0d expected 2", ok, ack_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    cfg_pulse = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_cfg_hold();
    test_timeout();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
